// File: rtl/bird_motion.sv
`default_nettype none
// ============================================================================
//  Module   : bird_motion
//  Purpose  : Vertical motion of the bird. A periodic gravity tick lowers the
//             row index and a flap pulse raises it. The block also detects
//             death from hitting the ground or from a pipe crash.
//  Options  : CEILING_KILL_EN - when defined, a flap that would carry the
//             bird above the top row kills it instead of saturating.
//  Revision : 1.0 - initial release
// ============================================================================
module bird_motion #(
    parameter int ROWS        = 16,
    parameter int START_ROW   = 8,
    parameter int RISE_ROWS   = 2,
    parameter int TICK_CYCLES = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,     // asynchronous, active low
    input  logic                    flap,
    input  logic                    crash,
    input  logic                    restart,
    output logic [$clog2(ROWS)-1:0] bird_y,
    output logic                    alive,
    output logic                    dead
);

    localparam int YW = $clog2(ROWS);
    localparam int DW = $clog2(TICK_CYCLES);

    // Lift is summed one bit wider than the row index so the top never wraps.
    localparam logic [YW:0]   c_TOP_W     = (YW+1)'(ROWS - 1);
    localparam logic [YW:0]   c_RISE_W    = (YW+1)'(RISE_ROWS);
    localparam logic [YW-1:0] c_TOP_Y     = YW'(ROWS - 1);
    localparam logic [YW-1:0] c_START_Y   = YW'(START_ROW);
    localparam logic [DW-1:0] c_TICK_LAST = DW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [YW-1:0]   y_q, y_d;
    logic [DW-1:0]   div_q, div_d;
    logic            alive_q, dead_q;

    logic            w_tick;
    logic [YW:0]     w_lift_sum;
    logic            w_lift_over;
    logic [YW-1:0]   w_lift_sat;
    logic [YW:0]     w_entry_sum;
    logic [YW-1:0]   w_entry_sat;

    // Gravity tick fires on the last count of the divider, only while flying.
    assign w_tick = (state_q == S_FLY) && (div_q == c_TICK_LAST);

    // Flap lift from the current row, saturated at the top row.
    assign w_lift_sum  = {1'b0, y_q} + c_RISE_W;
    assign w_lift_over = (w_lift_sum > c_TOP_W);
    assign w_lift_sat  = w_lift_over ? c_TOP_Y : w_lift_sum[YW-1:0];

    // The flap that starts a flight lifts from the start row.
    assign w_entry_sum = {1'b0, c_START_Y} + c_RISE_W;
    assign w_entry_sat = (w_entry_sum > c_TOP_W) ? c_TOP_Y : w_entry_sum[YW-1:0];

    // Next-state logic: crash beats flap, flap beats the gravity tick.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        div_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                y_d = c_START_Y;
                if (flap) begin
                    state_d = S_FLY;
                    y_d     = w_entry_sat;
                end
            end
            S_FLY: begin
                if (crash) begin
                    state_d = S_DEAD;
                end else if (flap) begin
`ifdef CEILING_KILL_EN
                    if (w_lift_over) begin
                        state_d = S_DEAD;
                        y_d     = c_TOP_Y;
                    end else begin
                        y_d = w_lift_sat;
                    end
`else
                    y_d = w_lift_sat;
`endif
                end else if (w_tick) begin
                    // Ground contact: die at row 0 rather than decrementing.
                    if (y_q == '0) begin
                        state_d = S_DEAD;
                    end else begin
                        y_d = y_q - YW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DEAD: begin
                if (restart) begin
                    state_d = S_IDLE;
                    y_d     = c_START_Y;
                end
            end
            default: begin
                state_d = S_IDLE;
                y_d     = c_START_Y;
            end
        endcase
    end

    // State, row, divider and decoded status flags are all registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            y_q     <= c_START_Y;
            div_q   <= '0;
            alive_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            div_q   <= div_d;
            alive_q <= (state_d == S_FLY);
            dead_q  <= (state_d == S_DEAD);
        end
    end

    assign bird_y = y_q;
    assign alive  = alive_q;
    assign dead   = dead_q;

endmodule
`default_nettype wire
